noc_packet_injector: RTL and testbench

Network-interface transmitter that drives a router's local upstream input port. It accepts a packet descriptor and a stream of payload words from the local core. It segments each packet into HEAD/BODY/TAIL flits tagged with a virtual channel, and issues them under credit-based flow control using credits returned by the router's input buffer. It is the sending end of the router input protocol, and one instance sits between each core and its router.

---
 rtl/noc_packet_injector.sv | 192 +++++++++++++++++++
 tb/tb_noc_packet_injector.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_injector.sv
// noc_packet_injector: network-interface transmitter feeding a router's local
// input port. It turns packet descriptors and payload words into HEAD, BODY and
// TAIL flits, tags each flit with a virtual channel, and sends only while it
// holds credit for that channel.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   pkt_valid/pkt_ready       descriptor handshake
//   pkt_x_dest/y_dest/len     descriptor fields, latched on the handshake
//   pay_valid/ready/data      payload word handshake
//   flit_valid, flit_data     registered flit output {type, vc, data}
//   credit_valid, credit_vc   one credit returned by the router
//   busy                      high whenever the FSM is not idle
module noc_packet_injector #(
    parameter int DATA_SIZE        = 32,
    parameter int VC_NUM           = 2,
    parameter int BUFFER_SIZE      = 8,
    parameter int DEST_ADDR_SIZE_X = 2,
    parameter int DEST_ADDR_SIZE_Y = 2,
    parameter int LEN_SIZE         = 4,
    localparam int VC_W            = $clog2(VC_NUM),
    localparam int FLIT_W          = 2 + VC_W + DATA_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pkt_valid,
    output logic                        pkt_ready,
    input  logic [DEST_ADDR_SIZE_X-1:0] pkt_x_dest,
    input  logic [DEST_ADDR_SIZE_Y-1:0] pkt_y_dest,
    input  logic [LEN_SIZE-1:0]         pkt_len,
    input  logic                        pay_valid,
    output logic                        pay_ready,
    input  logic [DATA_SIZE-1:0]        pay_data,
    output logic                        flit_valid,
    output logic [FLIT_W-1:0]           flit_data,
    input  logic                        credit_valid,
    input  logic [VC_W-1:0]             credit_vc,
    output logic                        busy
);

    localparam int CRED_W = $clog2(BUFFER_SIZE) + 1;
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUFFER_SIZE);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_HEAD    = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;

    localparam logic [1:0] FT_HEAD     = 2'b00;
    localparam logic [1:0] FT_BODY     = 2'b01;
    localparam logic [1:0] FT_TAIL     = 2'b10;
    localparam logic [1:0] FT_HEADTAIL = 2'b11;

    logic [1:0]                  state;
    logic [DEST_ADDR_SIZE_X-1:0] x_q;
    logic [DEST_ADDR_SIZE_Y-1:0] y_q;
    logic [LEN_SIZE-1:0]         len_q;
    logic [LEN_SIZE-1:0]         remaining;
    logic [VC_W-1:0]             cur_vc;
    logic [VC_W-1:0]             rr_ptr;
    logic [CRED_W-1:0]           credit [VC_NUM];

    logic                        found;
    logic [VC_W-1:0]             pick_vc;
    logic [VC_W-1:0]             cand;
    logic [DATA_SIZE-1:0]        head_data;
    logic                        head_go;
    logic                        pay_go;
    logic                        send;
    logic [VC_W-1:0]             send_vc;
    logic [VC_NUM-1:0]           cr_inc;
    logic [VC_NUM-1:0]           cr_dec;

    // Round-robin search starting one past the last used VC. The sum wraps
    // naturally because VC_NUM is a power of two; the last candidate is
    // rr_ptr itself.
    always_comb begin
        found   = 1'b0;
        pick_vc = '0;
        cand    = '0;
        for (int i = 1; i <= VC_NUM; i++) begin
            cand = rr_ptr + VC_W'(i);
            if (!found && credit[cand] != '0) begin
                found   = 1'b1;
                pick_vc = cand;
            end
        end
    end

    always_comb begin
        head_data = '0;
        head_data[DEST_ADDR_SIZE_X-1:0] = x_q;
        head_data[DEST_ADDR_SIZE_X +: DEST_ADDR_SIZE_Y] = y_q;
        head_data[DEST_ADDR_SIZE_X+DEST_ADDR_SIZE_Y +: LEN_SIZE] = len_q;
    end

    assign pkt_ready = (state == S_IDLE) && !rst;
    assign pay_ready = (state == S_PAYLOAD) && !rst
                       && (credit[cur_vc] != '0);
    assign busy      = (state != S_IDLE);

    assign head_go = (state == S_HEAD) && found;
    assign pay_go  = pay_valid && pay_ready;
    assign send    = head_go || pay_go;
    assign send_vc = head_go ? pick_vc : cur_vc;

    always_comb begin
        cr_inc = '0;
        cr_dec = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            cr_inc[i] = credit_valid && (credit_vc == VC_W'(i));
            cr_dec[i] = send && (send_vc == VC_W'(i));
        end
    end

    // A send is only ever issued on a VC with nonzero credit, so the
    // decrement cannot underflow. A return onto a full counter is a
    // protocol error from the router and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VC_NUM; i++) begin
                credit[i] <= CRED_MAX;
            end
        end else begin
            for (int i = 0; i < VC_NUM; i++) begin
                case ({cr_inc[i], cr_dec[i]})
                    2'b10: begin
                        if (credit[i] != CRED_MAX) begin
                            credit[i] <= credit[i] + 1'b1;
                        end
                    end
                    2'b01: credit[i] <= credit[i] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            flit_valid <= 1'b0;
            flit_data  <= '0;
            x_q        <= '0;
            y_q        <= '0;
            len_q      <= '0;
            remaining  <= '0;
            cur_vc     <= '0;
            rr_ptr     <= VC_W'(VC_NUM - 1);
        end else begin
            flit_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pkt_valid && pkt_ready) begin
                        x_q   <= pkt_x_dest;
                        y_q   <= pkt_y_dest;
                        len_q <= pkt_len;
                        state <= S_HEAD;
                    end
                end
                S_HEAD: begin
                    if (found) begin
                        flit_valid <= 1'b1;
                        cur_vc     <= pick_vc;
                        rr_ptr     <= pick_vc;
                        if (len_q == '0) begin
                            flit_data <= {FT_HEADTAIL, pick_vc, head_data};
                            state     <= S_IDLE;
                        end else begin
                            flit_data <= {FT_HEAD, pick_vc, head_data};
                            remaining <= len_q;
                            state     <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (pay_go) begin
                        flit_valid <= 1'b1;
                        remaining  <= remaining - 1'b1;
                        if (remaining == LEN_SIZE'(1)) begin
                            flit_data <= {FT_TAIL, cur_vc, pay_data};
                            state     <= S_IDLE;
                        end else begin
                            flit_data <= {FT_BODY, cur_vc, pay_data};
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_packet_injector.sv
// tb_noc_packet_injector: directed, self-checking bench for the packet
// injector. A table of single-flit packets plus hand-written corner sequences.
module tb_noc_packet_injector;

    localparam int DW = 32;
    localparam int FW = 35;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pkt_valid = 1'b0;
    logic          pkt_ready;
    logic [1:0]    pkt_x_dest = '0;
    logic [1:0]    pkt_y_dest = '0;
    logic [3:0]    pkt_len = '0;
    logic          pay_valid;
    logic          pay_ready;
    logic [DW-1:0] pay_data;
    logic          flit_valid;
    logic [FW-1:0] flit_data;
    logic          credit_valid = 1'b0;
    logic [0:0]    credit_vc = '0;
    logic          busy;

    noc_packet_injector dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_x_dest   (pkt_x_dest),
        .pkt_y_dest   (pkt_y_dest),
        .pkt_len      (pkt_len),
        .pay_valid    (pay_valid),
        .pay_ready    (pay_ready),
        .pay_data     (pay_data),
        .flit_valid   (flit_valid),
        .flit_data    (flit_data),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int pr_cnt = 0;

    logic [FW-1:0] fq [$];
    int            tq [$];
    logic [DW-1:0] pq [$];
    logic          pr_s;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (flit_valid) begin
            fq.push_back(flit_data);
            tq.push_back(cyc);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (pay_ready) pr_cnt <= pr_cnt + 1;
    end

    // Payload source: offers the head of pq, pops it on a handshake edge.
    initial begin
        pay_valid = 1'b0;
        pay_data  = '0;
        pr_s      = 1'b0;
        forever begin
            @(negedge clk);
            pay_valid = (pq.size() > 0);
            pay_data  = (pq.size() > 0) ? pq[0] : '0;
            pr_s      = pay_ready;
            @(posedge clk);
            if (pay_valid && pr_s && pq.size() > 0) void'(pq.pop_front());
        end
    end

    function automatic logic [FW-1:0] mk(input logic [1:0] t,
                                         input logic v,
                                         input logic [31:0] d);
        return {t, v, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [1:0] x, input logic [1:0] y,
                            input logic [3:0] len);
        int n = 0;
        bit done = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            pkt_valid  = 1'b1;
            pkt_x_dest = x;
            pkt_y_dest = y;
            pkt_len    = len;
            if (pkt_ready) begin
                @(posedge clk);
                done = 1;
            end
            n++;
        end
        #1 pkt_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_pkt: pkt_ready=0 expected 1 within bound");
        end
    endtask

    task automatic give_credits(input logic v, input int n);
        @(negedge clk);
        credit_valid = 1'b1;
        credit_vc    = v;
        repeat (n) @(posedge clk);
        @(negedge clk);
        credit_valid = 1'b0;
    endtask

    task automatic expect_flit(input string name, input logic [FW-1:0] exp,
                               output int t);
        int n = 0;
        logic [FW-1:0] got;
        t = -1;
        while (fq.size() == 0 && n < 60) begin
            settle();
            n++;
        end
        checks++;
        if (fq.size() == 0) begin
            errors++;
            $display("FAIL %s: got no flit expected 0x%0h", name, exp);
        end else begin
            got = fq.pop_front();
            t   = tq.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
            end
        end
    endtask

    typedef struct {
        logic [1:0]  x;
        logic [1:0]  y;
        logic [3:0]  len;
        logic [1:0]  typ;
        logic        vc;
        logic [31:0] data;
    } vec_t;

    vec_t vt [5];

    initial begin
        int t, t0, t3, ce, b0, p0;

        vt[0] = '{2'd3, 2'd3, 4'd0, 2'b11, 1'b1, 32'hF};
        vt[1] = '{2'd0, 2'd1, 4'd0, 2'b11, 1'b0, 32'h4};
        vt[2] = '{2'd2, 2'd0, 4'd0, 2'b11, 1'b1, 32'h2};
        vt[3] = '{2'd1, 2'd3, 4'd0, 2'b11, 1'b0, 32'hD};
        vt[4] = '{2'd0, 2'd0, 4'd0, 2'b11, 1'b1, 32'h0};

        // Reset values
        repeat (3) settle();
        chk("rst_pkt_ready", 64'(pkt_ready), 64'(0));
        chk("rst_flit_valid", 64'(flit_valid), 64'(0));
        chk("rst_flit_data", 64'(flit_data), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_pay_ready", 64'(pay_ready), 64'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_pkt_ready", 64'(pkt_ready), 64'(1));

        // Single-flit packet
        b0 = busy_cnt;
        p0 = pr_cnt;
        send_pkt(2'd1, 2'd2, 4'd0);
        expect_flit("t1_headtail", mk(2'b11, 1'b0, 32'h9), t);
        repeat (3) settle();
        chk("t1_busy_cycles", 64'(busy_cnt - b0), 64'(1));
        chk("t1_no_pay_ready", 64'(pr_cnt - p0), 64'(0));
        chk("t1_hold_valid", 64'(flit_valid), 64'(0));
        chk("t1_hold_data", 64'(flit_data), 64'(mk(2'b11, 1'b0, 32'h9)));
        give_credits(1'b0, 1);

        // Table of single-flit packets, alternating VCs
        for (int i = 0; i < 5; i++) begin
            send_pkt(vt[i].x, vt[i].y, vt[i].len);
            expect_flit($sformatf("vec%0d", i),
                        mk(vt[i].typ, vt[i].vc, vt[i].data), t);
            give_credits(vt[i].vc, 1);
        end

        // Back-to-back packets
        pq.push_back(32'hA);
        pq.push_back(32'hB);
        pq.push_back(32'hC);
        pq.push_back(32'hD);
        send_pkt(2'd0, 2'd0, 4'd3);
        send_pkt(2'd2, 2'd1, 4'd1);
        expect_flit("t2_head", mk(2'b00, 1'b0, 32'h30), t0);
        expect_flit("t2_body_a", mk(2'b01, 1'b0, 32'hA), t);
        expect_flit("t2_body_b", mk(2'b01, 1'b0, 32'hB), t);
        expect_flit("t2_tail_c", mk(2'b10, 1'b0, 32'hC), t3);
        chk("t2_consecutive", 64'(t3 - t0), 64'(3));
        expect_flit("t2_head2", mk(2'b00, 1'b1, 32'h16), t);
        chk("t2_period", 64'(t - t0), 64'(5));
        expect_flit("t2_tail2", mk(2'b10, 1'b1, 32'hD), t);
        give_credits(1'b0, 4);
        give_credits(1'b1, 2);

        // Credit exhaustion
        for (int i = 0; i < 10; i++) pq.push_back(32'h100 + i);
        send_pkt(2'd1, 2'd1, 4'd10);
        expect_flit("t3_head", mk(2'b00, 1'b0, 32'hA5), t);
        for (int i = 0; i < 7; i++)
            expect_flit($sformatf("t3_body%0d", i),
                        mk(2'b01, 1'b0, 32'h100 + i), t);
        repeat (4) settle();
        chk("t3_stall_noflit", 64'(fq.size()), 64'(0));
        chk("t3_stall_pay_ready", 64'(pay_ready), 64'(0));
        chk("t3_stall_busy", 64'(busy), 64'(1));
        give_credits(1'b0, 1);
        #1;
        chk("t3_ready_after_credit", 64'(pay_ready), 64'(1));
        expect_flit("t3_body7", mk(2'b01, 1'b0, 32'h107), t);
        repeat (4) settle();
        chk("t3_one_more_only", 64'(fq.size()), 64'(0));
        chk("t3_restall", 64'(pay_ready), 64'(0));
        give_credits(1'b0, 2);
        expect_flit("t3_body8", mk(2'b01, 1'b0, 32'h108), t);
        expect_flit("t3_tail", mk(2'b10, 1'b0, 32'h109), t);
        give_credits(1'b0, 8);

        // Simultaneous send and return on vc0
        send_pkt(2'd2, 2'd2, 4'd0);
        expect_flit("t4_pre", mk(2'b11, 1'b1, 32'hA), t);
        give_credits(1'b1, 1);
        for (int i = 0; i < 8; i++) pq.push_back(32'h200 + i);
        send_pkt(2'd0, 2'd1, 4'd8);
        give_credits(1'b0, 1);
        expect_flit("t4_head", mk(2'b00, 1'b0, 32'h84), t0);
        for (int i = 0; i < 7; i++)
            expect_flit($sformatf("t4_body%0d", i),
                        mk(2'b01, 1'b0, 32'h200 + i), t);
        expect_flit("t4_tail", mk(2'b10, 1'b0, 32'h207), t);
        chk("t4_no_stall", 64'(t - t0), 64'(8));
        give_credits(1'b0, 8);

        // Return onto a full counter is dropped; vc1 still has only 8
        give_credits(1'b1, 1);
        for (int i = 0; i < 8; i++) pq.push_back(32'h300 + i);
        send_pkt(2'd1, 2'd0, 4'd8);
        expect_flit("t5_head", mk(2'b00, 1'b1, 32'h81), t);
        for (int i = 0; i < 7; i++)
            expect_flit($sformatf("t5_body%0d", i),
                        mk(2'b01, 1'b1, 32'h300 + i), t);
        repeat (4) settle();
        chk("t5_overflow_hold", 64'(fq.size()), 64'(0));
        chk("t5_overflow_ready", 64'(pay_ready), 64'(0));
        give_credits(1'b1, 1);
        expect_flit("t5_tail", mk(2'b10, 1'b1, 32'h307), t);

        // Drain vc0, then head stall
        for (int i = 0; i < 7; i++) pq.push_back(32'h400 + i);
        send_pkt(2'd2, 2'd3, 4'd7);
        expect_flit("t5_d_head", mk(2'b00, 1'b0, 32'h7E), t);
        for (int i = 0; i < 6; i++)
            expect_flit($sformatf("t5_d_body%0d", i),
                        mk(2'b01, 1'b0, 32'h400 + i), t);
        expect_flit("t5_d_tail", mk(2'b10, 1'b0, 32'h406), t);
        send_pkt(2'd3, 2'd0, 4'd0);
        repeat (4) settle();
        chk("t5_head_stall", 64'(fq.size()), 64'(0));
        chk("t5_stall_busy", 64'(busy), 64'(1));
        chk("t5_stall_valid", 64'(flit_valid), 64'(0));
        give_credits(1'b1, 1);
        ce = cyc;
        expect_flit("t5_head_vc1", mk(2'b11, 1'b1, 32'h3), t);
        chk("t5_head_latency", 64'(t - ce), 64'(1));

        // Reset mid-packet
        give_credits(1'b0, 5);
        for (int i = 0; i < 4; i++) pq.push_back(32'h500 + i);
        send_pkt(2'd0, 2'd2, 4'd4);
        expect_flit("t6_head", mk(2'b00, 1'b0, 32'h48), t);
        expect_flit("t6_body0", mk(2'b01, 1'b0, 32'h500), t);
        expect_flit("t6_body1", mk(2'b01, 1'b0, 32'h501), t);
        rst = 1'b1;
        settle();
        chk("t6_rst_valid", 64'(flit_valid), 64'(0));
        chk("t6_rst_data", 64'(flit_data), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_pay_ready", 64'(pay_ready), 64'(0));
        chk("t6_rst_pkt_ready", 64'(pkt_ready), 64'(0));
        rst = 1'b0;
        pq.delete();
        repeat (3) settle();
        chk("t6_no_tail", 64'(fq.size()), 64'(0));
        for (int i = 0; i < 9; i++) pq.push_back(32'h600 + i);
        send_pkt(2'd1, 2'd2, 4'd8);
        expect_flit("t6_new_head", mk(2'b00, 1'b0, 32'h89), t);
        for (int i = 0; i < 7; i++)
            expect_flit($sformatf("t6_body%0d", i),
                        mk(2'b01, 1'b0, 32'h600 + i), t);
        repeat (4) settle();
        chk("t6_credit_full", 64'(fq.size()), 64'(0));
        chk("t6_credit_stall", 64'(pay_ready), 64'(0));
        rst = 1'b1;
        repeat (2) settle();
        rst = 1'b0;
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
